// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit ID codes carried in the flit MSBs and the
// switch-arbiter FSM encoding.
package noc_pkg;

    localparam logic [1:0] FLIT_BODY      = 2'b00;
    localparam logic [1:0] FLIT_HEAD      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ALLOC = 1'b1
    } sw_state_e;

endpackage

// File: rtl/vc_switch_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after ptr, wrapping around.
import noc_pkg::*;

module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int   w_idx;
    logic w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_switch_arbiter.sv
// Output-port controller: wormhole VC allocation with round-robin grant on
// head flits, credit-based flow control and a registered output flit.
import noc_pkg::*;

module vc_switch_arbiter #(
    parameter int VC_NUM      = 4,
    parameter int DATA_W      = 10,
    parameter int ID_W        = 2,
    parameter int BUF_DEPTH_W = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [VC_NUM-1:0]        vc_req_i,
    input  logic [VC_NUM*DATA_W-1:0] vc_data_i,
    input  logic [VC_NUM-1:0]        vc_vld_i,
    output logic [VC_NUM-1:0]        vc_alloc_o,
    output logic [VC_NUM-1:0]        vc_rdy_o,
    input  logic                     credit_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     data_vld_o,
    output logic                     busy_o
);

    localparam int PW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int CW = BUF_DEPTH_W + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(2 ** BUF_DEPTH_W);

    sw_state_e           r_state;
    logic [VC_NUM-1:0]   r_alloc;
    logic [PW-1:0]       r_ptr;
    logic [CW-1:0]       r_credits;
    logic [DATA_W-1:0]   r_data;
    logic                r_vld;

    logic [VC_NUM-1:0]   w_gnt;
    logic [VC_NUM-1:0]   w_rdy;
    logic [PW-1:0]       w_gidx;
    logic [DATA_W-1:0]   w_sel_data;
    logic [ID_W-1:0]     w_id;
    logic                w_pop;
    logic                w_tail;

    rr_arbiter #(.N(VC_NUM), .PW(PW)) u_rr (
        .req (vc_req_i),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    // Ready depends only on registered state, so no path from vc_vld_i.
    assign w_rdy = r_alloc & {VC_NUM{r_credits != '0}};
    assign w_pop = |(w_rdy & vc_vld_i);

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < VC_NUM; i++)
            if (r_alloc[i]) w_gidx = PW'(i);
    end

    assign w_sel_data = vc_data_i[w_gidx*DATA_W +: DATA_W];
    assign w_id       = w_sel_data[DATA_W-1 -: ID_W];
    assign w_tail     = (w_id == ID_W'(FLIT_TAIL)) || (w_id == ID_W'(FLIT_HEAD_TAIL));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_alloc <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|vc_req_i) begin
                        r_alloc <= w_gnt;
                        r_state <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (w_pop && w_tail) begin
                        r_alloc <= '0;
                        r_state <= ST_IDLE;
                        r_ptr   <= (w_gidx == PW'(VC_NUM - 1)) ? '0 : w_gidx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= w_pop;
            if (w_pop) r_data <= w_sel_data;
        end
    end

    // Pop and returned credit in the same cycle cancel out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_credits <= CRED_MAX;
        end else begin
            case ({w_pop, credit_i})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   if (r_credits != CRED_MAX) r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign vc_alloc_o = r_alloc;
    assign vc_rdy_o   = w_rdy;
    assign data_o     = r_data;
    assign data_vld_o = r_vld;
    assign busy_o     = (r_state == ST_ALLOC);

endmodule

// File: tb/tb_vc_switch_arbiter.sv
// Directed bench for vc_switch_arbiter: allocation, rotation, credits,
// bubbles and asynchronous reset.
module tb_vc_switch_arbiter;

    localparam int VC_NUM = 4;
    localparam int DATA_W = 10;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic [VC_NUM-1:0]        vc_req_i;
    logic [VC_NUM*DATA_W-1:0] vc_data_i;
    logic [VC_NUM-1:0]        vc_vld_i;
    logic [VC_NUM-1:0]        vc_alloc_o;
    logic [VC_NUM-1:0]        vc_rdy_o;
    logic                     credit_i;
    logic [DATA_W-1:0]        data_o;
    logic                     data_vld_o;
    logic                     busy_o;

    int n_pass = 0;
    int n_total = 0;
    int pops;
    int g;

    vc_switch_arbiter #(.VC_NUM(4), .DATA_W(10), .ID_W(2), .BUF_DEPTH_W(2)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .vc_req_i   (vc_req_i),
        .vc_data_i  (vc_data_i),
        .vc_vld_i   (vc_vld_i),
        .vc_alloc_o (vc_alloc_o),
        .vc_rdy_o   (vc_rdy_o),
        .credit_i   (credit_i),
        .data_o     (data_o),
        .data_vld_o (data_vld_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_flit(input int n, input logic [DATA_W-1:0] f);
        vc_data_i[n*DATA_W +: DATA_W] = f;
    endtask

    function automatic logic [DATA_W-1:0] head_of(input int n);
        return {2'b01, 8'(n * 16 + 1)};
    endfunction

    function automatic logic [DATA_W-1:0] tail_of(input int n);
        return {2'b10, 8'(n * 16 + 2)};
    endfunction

    initial begin
        rst_i = 1'b1; vc_req_i = '0; vc_data_i = '0; vc_vld_i = '0; credit_i = 1'b0;
        tick(); tick();
        check("rst_alloc", 32'(vc_alloc_o), 0);
        check("rst_rdy", 32'(vc_rdy_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_vld", 32'(data_vld_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_credits", 32'(dut.r_credits), 4);
        rst_i = 1'b0;

        // single HEAD_TAIL from VC1
        vc_req_i = 4'b0010; vc_vld_i = 4'b0010; set_flit(1, 10'h3A5);
        tick();
        check("ht_alloc", 32'(vc_alloc_o), 32'b0010);
        check("ht_rdy", 32'(vc_rdy_o), 32'b0010);
        check("ht_busy", 32'(busy_o), 1);
        vc_req_i = '0;
        tick();
        vc_vld_i = '0;
        check("ht_data", 32'(data_o), 32'h3A5);
        check("ht_vld", 32'(data_vld_o), 1);
        check("ht_busy_drop", 32'(busy_o), 0);
        check("ht_ptr", 32'(dut.r_ptr), 2);
        credit_i = 1'b1; tick(); credit_i = 1'b0;
        check("ht_credit_back", 32'(dut.r_credits), 4);

        // round robin: every VC requests 2-flit packets; rotation from ptr=2
        credit_i = 1'b1;
        vc_req_i = 4'b1111; vc_vld_i = 4'b1111;
        for (int n = 0; n < VC_NUM; n++) set_flit(n, head_of(n));
        for (int p = 0; p < 4; p++) begin
            g = (2 + p) % VC_NUM;
            tick();
            check("rr_grant", 32'(vc_alloc_o), 32'(1 << g));
            tick();
            check("rr_head", 32'(data_o), 32'(head_of(g)));
            set_flit(g, tail_of(g));
            tick();
            check("rr_tail", 32'(data_o), 32'(tail_of(g)));
            check("rr_bubble", 32'(vc_alloc_o), 0);
            set_flit(g, head_of(g));
        end
        vc_req_i = '0; vc_vld_i = '0; credit_i = 1'b0;
        check("rr_credits", 32'(dut.r_credits), 4);

        // credit exhaustion: 6-flit packet on VC0 with no returned credits
        vc_req_i = 4'b0001; vc_vld_i = 4'b0001; set_flit(0, 10'h100);
        tick();
        check("cx_grant", 32'(vc_alloc_o), 32'b0001);
        vc_req_i = '0;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (data_vld_o) begin pops++; set_flit(0, 10'h011); end
        end
        check("cx_pops4", 32'(pops), 4);
        check("cx_rdy0", 32'(vc_rdy_o), 0);
        check("cx_busy", 32'(busy_o), 1);
        check("cx_credits0", 32'(dut.r_credits), 0);
        credit_i = 1'b1; tick(); credit_i = 1'b0;
        check("cx_rdy_back", 32'(vc_rdy_o), 32'b0001);
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (data_vld_o) pops++;
        end
        check("cx_pops1", 32'(pops), 1);
        check("cx_rdy0b", 32'(vc_rdy_o), 0);
        set_flit(0, 10'h2FF);
        credit_i = 1'b1; tick(); credit_i = 1'b0;
        tick();
        vc_vld_i = '0;
        check("cx_tail", 32'(data_o), 32'h2FF);
        check("cx_idle", 32'(busy_o), 0);
        check("cx_ptr", 32'(dut.r_ptr), 1);
        credit_i = 1'b1; tick(); tick(); credit_i = 1'b0;
        check("cr_two", 32'(dut.r_credits), 2);

        // pop and credit together at credits=2
        vc_req_i = 4'b0010; vc_vld_i = 4'b0010; set_flit(1, 10'h3C3);
        tick();
        vc_req_i = '0; credit_i = 1'b1;
        tick();
        credit_i = 1'b0; vc_vld_i = '0;
        check("cr_both_vld", 32'(data_vld_o), 1);
        check("cr_both", 32'(dut.r_credits), 2);
        credit_i = 1'b1; tick(); tick(); tick(); credit_i = 1'b0;
        check("cr_sat", 32'(dut.r_credits), 4);

        // bubble hold on VC2 while VC3 waits
        vc_req_i = 4'b0100; vc_vld_i = 4'b0100; set_flit(2, 10'h1AA);
        tick();
        check("bh_grant", 32'(vc_alloc_o), 32'b0100);
        vc_req_i = 4'b1100; vc_vld_i = 4'b1100; set_flit(3, 10'h3BB);
        tick();
        check("bh_head", 32'(data_o), 32'h1AA);
        vc_vld_i = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bh_gap_vld", 32'(data_vld_o), 0);
            check("bh_gap_alloc", 32'(vc_alloc_o), 32'b0100);
        end
        vc_vld_i = 4'b1100; set_flit(2, 10'h0AB);
        tick();
        check("bh_body", 32'(data_o), 32'h0AB);
        set_flit(2, 10'h2AC);
        tick();
        check("bh_tail", 32'(data_o), 32'h2AC);
        check("bh_release", 32'(vc_alloc_o), 0);
        vc_req_i = 4'b1000; vc_vld_i = 4'b1000;
        tick();
        check("bh_vc3", 32'(vc_alloc_o), 32'b1000);
        tick();
        vc_req_i = '0; vc_vld_i = '0;
        check("bh_vc3_data", 32'(data_o), 32'h3BB);
        credit_i = 1'b1; tick(); tick(); tick(); tick(); credit_i = 1'b0;

        // asynchronous reset during a body flit
        vc_req_i = 4'b0010; vc_vld_i = 4'b0010; set_flit(1, 10'h1C1);
        tick();
        vc_req_i = '0;
        tick();
        set_flit(1, 10'h0C2);
        check("ar_pre_busy", 32'(busy_o), 1);
        #3 rst_i = 1'b1;
        #1;
        check("ar_alloc", 32'(vc_alloc_o), 0);
        check("ar_rdy", 32'(vc_rdy_o), 0);
        check("ar_data", 32'(data_o), 0);
        check("ar_vld", 32'(data_vld_o), 0);
        check("ar_busy", 32'(busy_o), 0);
        check("ar_credits", 32'(dut.r_credits), 4);
        tick();
        rst_i = 1'b0; vc_vld_i = 4'b1001; vc_req_i = 4'b1001;
        set_flit(0, 10'h3D0); set_flit(3, 10'h3D3);
        tick();
        check("ar_vc0_prio", 32'(vc_alloc_o), 32'b0001);
        vc_req_i = '0; vc_vld_i = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
